reg_bus_initiator: RTL and testbench

REG_BUS_INITIATOR -- requirements
Module: reg_bus_initiator

---
 rtl/reg_bus_pkg.sv | 15 +
 rtl/reg_bus_initiator_if.sv | 37 +++
 rtl/reg_bus_initiator.sv | 103 ++++++++++
 tb/tb_reg_bus_initiator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared constants and state encoding for the register-bus initiator.
package reg_bus_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bus_initiator_if.sv
// Command/response and peripheral bus signals of the register-bus initiator.
interface reg_bus_initiator_if
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  // master: the initiator itself; slave: command source plus peripheral
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_ack, bus_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_ack, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_req, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/reg_bus_initiator.sv
// Single-outstanding register-bus initiator with ack timeout.
//   state     | meaning
//   ST_IDLE   | cmd_ready high, waiting for a command
//   ST_ACCESS | bus_req held, waiting for bus_ack or timeout
//   ST_RESP   | result latched, publishes rsp_valid on the way back to IDLE
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  reg_bus_initiator_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_bus_req;
  logic               r_bus_we;
  logic [ADDR_W-1:0]  r_bus_addr;
  logic [DATA_W-1:0]  r_bus_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_hold_rdata;
  logic               r_hold_err;

  // Result is staged so rsp_rdata/rsp_err only change together with rsp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_cnt        <= '0;
      r_hold_rdata <= '0;
      r_hold_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_bus_we    <= bus.cmd_write;
            r_bus_addr  <= bus.cmd_addr;
            r_bus_wdata <= bus.cmd_wdata;
            r_bus_req   <= 1'b1;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // ack takes priority over the timeout limit
          if (bus.bus_ack) begin
            r_bus_req    <= 1'b0;
            r_hold_rdata <= r_bus_we ? '0 : bus.bus_rdata;
            r_hold_err   <= 1'b0;
            r_state      <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_bus_req    <= 1'b0;
            r_hold_rdata <= '0;
            r_hold_err   <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_hold_rdata;
          r_rsp_err   <= r_hold_err;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_bus_req   <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Self-checking bench for reg_bus_initiator: directed cases plus randomized commands vs. a timing model.
module tb_reg_bus_initiator;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_rd  = 32'h0;
  logic        last_err = 1'b0;

  always #5 clk = ~clk;

  reg_bus_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  reg_bus_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ":cmd_ready"}, 32'(bif.cmd_ready), 32'd1);
    check({nm, ":rsp_valid"}, 32'(bif.rsp_valid), 32'd0);
    check({nm, ":rsp_rdata"}, bif.rsp_rdata, 32'd0);
    check({nm, ":rsp_err"},   32'(bif.rsp_err),   32'd0);
    check({nm, ":bus_req"},   32'(bif.bus_req),   32'd0);
    check({nm, ":bus_we"},    32'(bif.bus_we),    32'd0);
    check({nm, ":bus_addr"},  32'(bif.bus_addr),  32'd0);
    check({nm, ":bus_wdata"}, bif.bus_wdata,      32'd0);
  endtask

  // One command from IDLE; dly = number of silent ACCESS cycles before ack.
  // Model: ack inside the window -> data, no error; otherwise bus_req lasts TIMEOUT cycles, error.
  task automatic run_cmd(input bit we, input logic [7:0] a, input logic [31:0] wd,
                         input int dly, input logic [31:0] rd, input string nm);
    bit          tmo;
    int          acc;
    logic [31:0] e_rd;
    bit          e_err;
    tmo   = (dly >= TIMEOUT);
    acc   = tmo ? TIMEOUT : dly + 1;
    e_rd  = (tmo || we) ? 32'h0 : rd;
    e_err = tmo;
    check({nm, ":ready_idle"}, 32'(bif.cmd_ready), 32'd1);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = we;
    bif.cmd_addr  = a;
    bif.cmd_wdata = wd;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'($urandom);
    bif.cmd_addr  = 8'($urandom);
    bif.cmd_wdata = $urandom;
    for (int c = 0; c <= acc + 2; c++) begin
      check({nm, ":bus_req"}, 32'(bif.bus_req), 32'(c < acc));
      if (c < acc) begin
        check({nm, ":bus_we"},    32'(bif.bus_we),   32'(we));
        check({nm, ":bus_addr"},  32'(bif.bus_addr), 32'(a));
        check({nm, ":bus_wdata"}, bif.bus_wdata,     wd);
      end
      check({nm, ":rsp_valid"}, 32'(bif.rsp_valid), 32'(c == acc + 1));
      check({nm, ":cmd_ready"}, 32'(bif.cmd_ready), 32'(c >= acc + 1));
      check({nm, ":rsp_rdata"}, bif.rsp_rdata, (c >= acc + 1) ? e_rd : last_rd);
      check({nm, ":rsp_err"},   32'(bif.rsp_err), 32'((c >= acc + 1) ? e_err : last_err));
      bif.bus_ack   = (c == dly) || (c >= acc && $urandom_range(0, 1) == 1);
      bif.bus_rdata = (c == dly) ? rd : $urandom;
      @(negedge clk);
    end
    bif.bus_ack = 1'b0;
    last_rd  = e_rd;
    last_err = e_err;
  endtask

  initial begin
    logic [7:0]  b2b_addr [3];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int          acc_cyc [3];
    int          idx;
    int          req_rises;
    bit          prev_ready;
    bit          prev_req;

    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_wdata = '0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_cmd(1'b1, 8'h04, 32'hDEADBEEF, 0, 32'h0BADF00D, "wr_ack0");
    run_cmd(1'b0, 8'h08, 32'h0, 5, 32'h12345678, "rd_ack5");
    run_cmd(1'b0, 8'h0C, 32'h0, 100, 32'h55AA55AA, "rd_timeout");
    run_cmd(1'b0, 8'h0D, 32'h0, TIMEOUT - 1, 32'hA1B2C3D4, "rd_ack_at_limit");
    run_cmd(1'b1, 8'h0E, 32'h01020304, TIMEOUT, 32'hFFFFFFFF, "wr_ack_late");

    for (int n = 0; n < 24; n++) begin
      int sel;
      int dly;
      sel = $urandom_range(0, 9);
      if (sel < 6)      dly = $urandom_range(0, 4);
      else if (sel < 8) dly = $urandom_range(5, TIMEOUT - 1);
      else              dly = $urandom_range(TIMEOUT, TIMEOUT + 2);
      run_cmd(1'($urandom), 8'($urandom), $urandom, dly, $urandom, "rand");
    end

    // Back-to-back with cmd_valid held high; peripheral acks on the first ACCESS cycle.
    b2b_addr[0] = 8'h10;
    b2b_addr[1] = 8'h21;
    b2b_addr[2] = 8'h32;
    for (int k = 0; k < 3; k++) begin
      acc_cyc[k] = -1;
      exp_q.push_back({24'hA55AC3, b2b_addr[k]});
    end
    idx        = 0;
    req_rises  = 0;
    prev_req   = 1'b0;
    prev_ready = bif.cmd_ready;
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = b2b_addr[0];
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (prev_ready && bif.cmd_valid) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx < 3) bif.cmd_addr = b2b_addr[idx];
        else         bif.cmd_valid = 1'b0;
      end
      if (bif.bus_req) begin
        check("b2b:ready_low_in_access", 32'(bif.cmd_ready), 32'd0);
        if (!prev_req) begin
          check("b2b:bus_addr_order", 32'(bif.bus_addr), 32'(b2b_addr[req_rises % 3]));
          req_rises++;
        end
      end
      if (bif.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b:extra_response", 32'(bif.rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("b2b:rsp_rdata", bif.rsp_rdata, e);
          check("b2b:rsp_err", 32'(bif.rsp_err), 32'd0);
          last_rd  = e;
          last_err = 1'b0;
        end
      end
      prev_ready    = bif.cmd_ready;
      prev_req      = bif.bus_req;
      bif.bus_ack   = bif.bus_req;
      bif.bus_rdata = {24'hA55AC3, bif.bus_addr};
    end
    bif.bus_ack = 1'b0;
    check("b2b:accepted", 32'(idx), 32'd3);
    check("b2b:bus_transactions", 32'(req_rises), 32'd3);
    check("b2b:missing_responses", 32'(exp_q.size()), 32'd0);
    check("b2b:spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("b2b:spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    @(negedge clk);

    // Reset pulsed in the middle of an access that never gets acked.
    check("rst_mid:ready_idle", 32'(bif.cmd_ready), 32'd1);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 8'h33;
    bif.cmd_wdata = 32'hCAFEF00D;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid:in_access", 32'(bif.bus_req), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    last_rd  = 32'h0;
    last_err = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("rst_mid:no_rsp", 32'(bif.rsp_valid), 32'd0);
      check("rst_mid:no_req", 32'(bif.bus_req), 32'd0);
      @(negedge clk);
    end
    run_cmd(1'b0, 8'h44, 32'h0, 2, 32'h87654321, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
